// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: decodes host read/write frames popped from uart_comm's rx FIFO,
// drives a byte-wide memory port and pushes response frames into the tx FIFO.
// Ports:
//   CLK/RST                          clock, sync active-high reset
//   receivable/recv_flag/_data/_ack  rx FIFO pop handshake
//   sendable/send_flag/_data/_ack    tx FIFO push handshake
//   mem_req/we/addr/wdata/rdata/ack  byte memory port
//   busy                             FSM not idle
//   err                              one-cycle pulse on bad opcode, timeout or checksum failure
module uart_cmd_bridge #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              receivable,
  output logic              recv_flag,
  input  logic [7:0]        recv_data,
  input  logic              recv_ack,
  input  logic              sendable,
  output logic              send_flag,
  output logic [7:0]        send_data,
  input  logic              send_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int NB = ADDR_W / 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WMEM, S_RX_CK, S_RESP,
    S_TX_HDR, S_RMEM, S_TX_DATA, S_TX_CK, S_TX_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic              wr_q, wr_d;
  logic [7:0]        ck_q, ck_d;
  logic [7:0]        tck_q, tck_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              stat_q, stat_d;
  logic [1:0]        ridx_q, ridx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              recv_flag_q, recv_flag_d;
  logic              send_flag_q, send_flag_d;
  logic [7:0]        send_data_q, send_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic       rx_ack, tx_ack, m_ack;
  logic       rx_wait, tx_st, tmo_hit;
  logic [7:0] tx_byte;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_d        = wr_q;
    ck_d        = ck_q;
    tck_d       = tck_q;
    idx_d       = idx_q;
    rdata_d     = rdata_q;
    stat_d      = stat_q;
    ridx_d      = ridx_q;
    send_data_d = send_data_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;

    rx_ack  = recv_flag_q & recv_ack;
    tx_ack  = send_flag_q & send_ack;
    m_ack   = mem_req_q & mem_ack;
    rx_wait = state_q inside {S_ADDR, S_LEN, S_WDATA, S_RX_CK};
    tx_st   = state_q inside {S_RESP, S_TX_HDR, S_TX_DATA, S_TX_CK, S_TX_ERR};

    unique case (state_q)
      S_RESP: begin
        if (ridx_q == 2'd0)      tx_byte = 8'h57;
        else if (ridx_q == 2'd1) tx_byte = {7'd0, stat_q};
        else                     tx_byte = 8'h57 ^ {7'd0, stat_q};
      end
      S_TX_HDR:  tx_byte = 8'h52;
      S_TX_DATA: tx_byte = rdata_q;
      S_TX_CK:   tx_byte = tck_q;
      default:   tx_byte = 8'hEE;
    endcase

    // Handshake flags: held until ack, then low for at least one cycle.
    if (recv_flag_q) recv_flag_d = ~recv_ack;
    else recv_flag_d = ((state_q == S_IDLE) | rx_wait) & receivable;

    if (send_flag_q) send_flag_d = ~send_ack;
    else begin
      send_flag_d = tx_st & sendable;
      if (tx_st & sendable) send_data_d = tx_byte;
    end

    if (mem_req_q) mem_req_d = ~mem_ack;
    else begin
      mem_req_d = (state_q == S_WMEM) | (state_q == S_RMEM);
      if (state_q == S_WMEM) mem_we_d = 1'b1;
      if (state_q == S_RMEM) mem_we_d = 1'b0;
    end

    // Inter-byte watchdog, only while a frame is waiting on rx.
    if (!rx_wait || rx_ack) tmo_d = '0;
    else tmo_d = tmo_q + TW'(1);
    tmo_hit = rx_wait & ~rx_ack & (tmo_q == TW'(TIMEOUT_CYC - 1));

    if (tmo_hit) begin
      state_d     = S_IDLE;
      recv_flag_d = 1'b0;
      tmo_d       = '0;
      err_d       = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (rx_ack) begin
          ck_d  = recv_data;
          idx_d = 8'd0;
          wr_d  = (recv_data == 8'h57);
          if (recv_data == 8'h57 || recv_data == 8'h52) state_d = S_ADDR;
          else begin
            err_d   = 1'b1;
            state_d = S_TX_ERR;
          end
        end
        S_ADDR: if (rx_ack) begin
          // Little-endian: shift each byte in from the top.
          addr_d = ADDR_W'({recv_data, addr_q} >> 8);
          ck_d   = ck_q ^ recv_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q == 8'(NB - 1)) state_d = S_LEN;
        end
        S_LEN: if (rx_ack) begin
          len_d   = {(recv_data == 8'h00), recv_data};
          ck_d    = ck_q ^ recv_data;
          state_d = wr_q ? S_WDATA : S_RX_CK;
        end
        S_WDATA: if (rx_ack) begin
          ck_d        = ck_q ^ recv_data;
          mem_wdata_d = recv_data;
          state_d     = S_WMEM;
        end
        S_WMEM: if (m_ack) begin
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - 9'd1;
          state_d = (len_q == 9'd1) ? S_RX_CK : S_WDATA;
        end
        S_RX_CK: if (rx_ack) begin
          if (wr_q) begin
            stat_d  = (recv_data != ck_q);
            err_d   = (recv_data != ck_q);
            ridx_d  = 2'd0;
            state_d = S_RESP;
          end else if (recv_data == ck_q) state_d = S_TX_HDR;
          else begin
            err_d   = 1'b1;
            state_d = S_TX_ERR;
          end
        end
        S_RESP: if (tx_ack) begin
          ridx_d = ridx_q + 2'd1;
          if (ridx_q == 2'd2) state_d = S_IDLE;
        end
        S_TX_HDR: if (tx_ack) begin
          tck_d   = 8'h52;
          state_d = S_RMEM;
        end
        S_RMEM: if (m_ack) begin
          rdata_d = mem_rdata;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_TX_DATA;
        end
        S_TX_DATA: if (tx_ack) begin
          tck_d   = tck_q ^ rdata_q;
          len_d   = len_q - 9'd1;
          state_d = (len_q == 9'd1) ? S_TX_CK : S_RMEM;
        end
        S_TX_CK, S_TX_ERR: if (tx_ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wr_q        <= 1'b0;
      ck_q        <= '0;
      tck_q       <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      stat_q      <= 1'b0;
      ridx_q      <= '0;
      tmo_q       <= '0;
      recv_flag_q <= 1'b0;
      send_flag_q <= 1'b0;
      send_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_q        <= wr_d;
      ck_q        <= ck_d;
      tck_q       <= tck_d;
      idx_q       <= idx_d;
      rdata_q     <= rdata_d;
      stat_q      <= stat_d;
      ridx_q      <= ridx_d;
      tmo_q       <= tmo_d;
      recv_flag_q <= recv_flag_d;
      send_flag_q <= send_flag_d;
      send_data_q <= send_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign recv_flag = recv_flag_q;
  assign send_flag = send_flag_q;
  assign send_data = send_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: randomized frames against a frame-level reference model,
// with randomized rx/tx/memory handshake responders.
module tb_uart_cmd_bridge;

  localparam int AW  = 16;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          receivable, recv_flag, recv_ack;
  logic [7:0]    recv_data;
  logic          sendable, send_flag, send_ack;
  logic [7:0]    send_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          busy, err;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .RST(rst),
    .receivable(receivable), .recv_flag(recv_flag),
    .recv_data(recv_data), .recv_ack(recv_ack),
    .sendable(sendable), .send_flag(send_flag),
    .send_data(send_data), .send_ack(send_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  typedef logic [7:0]  bq_t[$];
  typedef logic [24:0] mq_t[$];

  bq_t        rx_q, tx_q;
  mq_t        mlog;
  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];
  int  n_cmp = 0, n_bad = 0;
  int  err_cnt = 0, excl_cnt = 0, sflag_cnt = 0;
  int  mem_lat = 0, lat_cnt = 0;
  bit  tx_rand = 1'b1;
  time t_ack = 0, t_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // rx FIFO model
  initial forever begin
    @(negedge clk);
    if (rst) recv_ack = 1'b0;
    else if (recv_ack) recv_ack = 1'b0;
    else if (recv_flag && rx_q.size() > 0 && $urandom_range(0, 1) == 0) begin
      recv_data = rx_q.pop_front();
      recv_ack  = 1'b1;
      t_ack     = $time;
    end
    receivable = (rx_q.size() > 0);
  end

  // memory model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_req) begin
      if (lat_cnt >= mem_lat && (mem_lat > 0 || $urandom_range(0, 1) == 0)) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          mlog.push_back({1'b1, mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr];
          mlog.push_back({1'b0, mem_addr, mem[mem_addr]});
        end
      end else lat_cnt++;
    end
  end

  // tx FIFO model
  initial forever begin
    @(negedge clk);
    if (rst) send_ack = 1'b0;
    else if (send_ack) send_ack = 1'b0;
    else if (send_flag && $urandom_range(0, 1) == 0) begin
      send_ack = 1'b1;
      tx_q.push_back(send_data);
    end
    if (tx_rand) sendable = ($urandom_range(0, 3) != 0);
  end

  // protocol monitor
  initial forever begin
    @(negedge clk);
    if (err) begin
      err_cnt++;
      t_err = $time;
    end
    if (int'(recv_flag) + int'(send_flag) + int'(mem_req) > 1) excl_cnt++;
    if (send_flag) sflag_cnt++;
  end

  task automatic run_frame(input string nm, input bq_t fr, input bq_t etx,
                           input mq_t em, input int eerr);
    int e0;
    int cyc;
    e0  = err_cnt;
    cyc = 0;
    tx_q.delete();
    mlog.delete();
    foreach (fr[i]) rx_q.push_back(fr[i]);
    while (!(rx_q.size() == 0 && !busy && tx_q.size() >= etx.size())
           && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " done"}, 64'(cyc < 20000), 64'd1);
    repeat (4) @(negedge clk);
    chk({nm, " tx_n"}, 64'(tx_q.size()), 64'(etx.size()));
    foreach (etx[i])
      if (i < tx_q.size()) chk($sformatf("%s tx%0d", nm, i), 64'(tx_q[i]), 64'(etx[i]));
    chk({nm, " mem_n"}, 64'(mlog.size()), 64'(em.size()));
    foreach (em[i])
      if (i < mlog.size()) chk($sformatf("%s mem%0d", nm, i), 64'(mlog[i]), 64'(em[i]));
    chk({nm, " err"}, 64'(err_cnt - e0), 64'(eerr));
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic do_write(input string nm, input logic [15:0] a,
                          input bq_t pl, input bit bad);
    bq_t fr, etx;
    mq_t em;
    logic [7:0] ck;
    logic [7:0] st;
    logic [15:0] p;
    fr.push_back(8'h57);
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      p = a + 16'(i);
      fr.push_back(pl[i]);
      em.push_back({1'b1, p, pl[i]});
      ref_mem[p] = pl[i];
    end
    ck = 8'h00;
    foreach (fr[i]) ck = ck ^ fr[i];
    if (bad) ck = ck ^ 8'($urandom_range(1, 255));
    fr.push_back(ck);
    st = bad ? 8'h01 : 8'h00;
    etx.push_back(8'h57);
    etx.push_back(st);
    etx.push_back(8'h57 ^ st);
    run_frame(nm, fr, etx, em, bad ? 1 : 0);
  endtask

  task automatic do_read(input string nm, input logic [15:0] a,
                         input int n, input bit bad);
    bq_t fr, etx;
    mq_t em;
    logic [7:0] ck;
    logic [15:0] p;
    fr.push_back(8'h52);
    fr.push_back(a[7:0]);
    fr.push_back(a[15:8]);
    fr.push_back(8'(n));
    ck = 8'h00;
    foreach (fr[i]) ck = ck ^ fr[i];
    if (bad) ck = ck ^ 8'($urandom_range(1, 255));
    fr.push_back(ck);
    if (bad) etx.push_back(8'hEE);
    else begin
      etx.push_back(8'h52);
      ck = 8'h52;
      for (int i = 0; i < n; i++) begin
        p = a + 16'(i);
        etx.push_back(ref_mem[p]);
        em.push_back({1'b0, p, ref_mem[p]});
        ck = ck ^ ref_mem[p];
      end
      etx.push_back(ck);
    end
    run_frame(nm, fr, etx, em, bad ? 1 : 0);
  endtask

  task automatic do_badop(input string nm, input logic [7:0] op);
    bq_t fr, etx;
    mq_t em;
    fr.push_back(op);
    etx.push_back(8'hEE);
    run_frame(nm, fr, etx, em, 1);
  endtask

  task automatic do_timeout();
    int e0;
    int cyc;
    int d;
    e0  = err_cnt;
    cyc = 0;
    tx_q.delete();
    mlog.delete();
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    while (err_cnt == e0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("tmo fired", 64'(err_cnt != e0), 64'd1);
    d = int'((t_err - t_ack) / 10);
    chk("tmo delay", 64'(d >= TMO && d <= TMO + 2), 64'd1);
    repeat (5) @(negedge clk);
    chk("tmo busy", 64'(busy), 64'd0);
    chk("tmo err_n", 64'(err_cnt - e0), 64'd1);
    chk("tmo tx_n", 64'(tx_q.size()), 64'd0);
    chk("tmo mem_n", 64'(mlog.size()), 64'd0);
  endtask

  task automatic do_reset_mid();
    bq_t fr;
    int cyc;
    int s0;
    cyc = 0;
    tx_q.delete();
    mlog.delete();
    mem_lat = 10;
    fr.push_back(8'h52);
    fr.push_back(8'h40);
    fr.push_back(8'h00);
    fr.push_back(8'h03);
    fr.push_back(8'h52 ^ 8'h40 ^ 8'h03);
    foreach (fr[i]) rx_q.push_back(fr[i]);
    while (!mem_req && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst rmem reached", 64'(mem_req), 64'd1);
    tx_rand  = 1'b0;
    sendable = 1'b0;
    s0 = sflag_cnt;
    repeat (30) @(negedge clk);
    chk("rst read acked", 64'(mlog.size()), 64'd1);
    chk("rst no send", 64'(sflag_cnt - s0), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst flags", 64'({recv_flag, send_flag, mem_req, mem_we}), 64'd0);
    chk("rst addr", 64'(mem_addr), 64'd0);
    chk("rst data", 64'({mem_wdata, send_data}), 64'd0);
    chk("rst busy_err", 64'({busy, err}), 64'd0);
    rx_q.delete();
    rst = 1'b0;
    mem_lat = 0;
    tx_rand = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bq_t pl;
    logic [7:0] op;
    int k;
    rst = 1'b1;
    receivable = 1'b0;
    recv_data = 8'h00;
    recv_ack = 1'b0;
    sendable = 1'b0;
    send_ack = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    chk("reset flags", 64'({recv_flag, send_flag, mem_req, mem_we}), 64'd0);
    chk("reset addr", 64'(mem_addr), 64'd0);
    chk("reset busy_err", 64'({busy, err}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle busy", 64'(busy), 64'd0);

    pl.delete();
    pl.push_back(8'hAA);
    pl.push_back(8'hBB);
    do_write("wr1000", 16'h1000, pl, 1'b0);

    mem[16'h20] = 8'h11; mem[16'h21] = 8'h22; mem[16'h22] = 8'h33;
    ref_mem[16'h20] = 8'h11; ref_mem[16'h21] = 8'h22; ref_mem[16'h22] = 8'h33;
    do_read("rd20", 16'h0020, 3, 1'b0);

    do_write("wr_badck", 16'h0300, rand_bytes(4), 1'b1);
    do_read("rd_badck_chk", 16'h0300, 4, 1'b0);
    do_read("rd_badck", 16'h0300, 2, 1'b1);

    do_badop("op13", 8'h13);
    do_read("rd_after_op", 16'h0020, 3, 1'b0);

    do_timeout();
    do_read("rd_after_tmo", 16'h1000, 2, 1'b0);

    do_write("wr_wrap", 16'hFFFE, rand_bytes(4), 1'b0);
    do_read("rd_wrap", 16'hFFFD, 6, 1'b0);

    do_write("wr_len256", 16'h4000, rand_bytes(256), 1'b0);
    do_read("rd_len256_tail", 16'h40FC, 4, 1'b0);

    do_reset_mid();
    do_read("rd_after_rst", 16'h0020, 3, 1'b0);

    for (int it = 0; it < 24; it++) begin
      k = $urandom_range(0, 5);
      if (k <= 1)
        do_write($sformatf("rnd%0d_wr", it), 16'($urandom),
                 rand_bytes($urandom_range(1, 8)), $urandom_range(0, 3) == 0);
      else if (k <= 3)
        do_read($sformatf("rnd%0d_rd", it), 16'($urandom),
                $urandom_range(1, 8), $urandom_range(0, 3) == 0);
      else if (k == 4) begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        do_badop($sformatf("rnd%0d_op", it), op);
      end else
        do_write($sformatf("rnd%0d_wrap", it), 16'hFFFC + 16'($urandom_range(0, 3)),
                 rand_bytes($urandom_range(3, 8)), 1'b0);
    end

    chk("one-hot handshakes", 64'(excl_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
